// File: rtl/layer_pwr_seq.sv
// Shared power sequencer for NUM_DOMAINS switchable domains; one wake or sleep sequence at a time.
// Optional build macro PWR_SEQ_INT_WAKE_EN adds INT_VECTOR as an extra wake source for INT_DOMAIN.
module layer_pwr_seq #(
  parameter int NUM_DOMAINS = 2,
  parameter int SEQ_DELAY   = 4,
  parameter int INT_DEPTH   = 13,
  parameter int INT_DOMAIN  = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_DOMAINS-1:0] WAKE_REQ,
  input  logic [NUM_DOMAINS-1:0] SLEEP_REQ,
`ifdef PWR_SEQ_INT_WAKE_EN
  input  logic [INT_DEPTH-1:0]   INT_VECTOR,
`endif
  output logic [NUM_DOMAINS-1:0] PWR_GATE,
  output logic [NUM_DOMAINS-1:0] CLK_HOLD,
  output logic [NUM_DOMAINS-1:0] RST_HOLD,
  output logic [NUM_DOMAINS-1:0] ISO,
  output logic [NUM_DOMAINS-1:0] DOMAIN_ON,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [2:0]             DONE_ID
);

  localparam int CW = $clog2(SEQ_DELAY + 1);
  localparam logic [CW-1:0] LOAD = CW'(SEQ_DELAY - 1);

  if (INT_DOMAIN < 0 || INT_DOMAIN >= NUM_DOMAINS || INT_DEPTH < 1) begin : g_bad_cfg
    $error("layer_pwr_seq: INT_DOMAIN/INT_DEPTH out of range");
  end

  typedef enum logic [3:0] {
    IDLE, W_PWR, W_CLK, W_RST, W_ISO, S_ISO, S_RST, S_CLK, S_PWR
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [NUM_DOMAINS-1:0] wake_eff, elig, sel_mask, cur_mask;
  logic                   sel_vld, sel_wake;
  logic [2:0]             sel_id;

  always_comb begin
    wake_eff = WAKE_REQ;
`ifdef PWR_SEQ_INT_WAKE_EN
    wake_eff[INT_DOMAIN] = WAKE_REQ[INT_DOMAIN] | (|INT_VECTOR);
`endif
    // A simultaneous wake request masks sleep, so an on domain asking for both stays put.
    elig = (wake_eff & ~DOMAIN_ON) | (SLEEP_REQ & ~wake_eff & DOMAIN_ON);
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_wake = 1'b0;
    sel_id   = 3'd0;
    sel_mask = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel_vld     = 1'b1;
        sel_wake    = wake_eff[i];
        sel_id      = 3'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE) begin
      if (sel_vld && !DONE) begin
        state_nxt = sel_wake ? W_PWR : S_ISO;
        cnt_nxt   = LOAD;
      end
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end else begin
      cnt_nxt = LOAD;
      case (state)
        W_PWR:   state_nxt = W_CLK;
        W_CLK:   state_nxt = W_RST;
        W_RST:   state_nxt = W_ISO;
        S_ISO:   state_nxt = S_RST;
        S_RST:   state_nxt = S_CLK;
        S_CLK:   state_nxt = S_PWR;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign BUSY = (state != IDLE);

  // Domain controls move only on the edge that enters a new state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PWR_GATE  <= '1;
      CLK_HOLD  <= '1;
      RST_HOLD  <= '1;
      ISO       <= '1;
      DOMAIN_ON <= '0;
      DONE      <= 1'b0;
      DONE_ID   <= 3'd0;
      cur_mask  <= '0;
    end else begin
      DONE <= (state != IDLE) && (state_nxt == IDLE);
      if (state == IDLE && state_nxt != IDLE) begin
        cur_mask <= sel_mask;
        DONE_ID  <= sel_id;
      end
      if (state_nxt != state) begin
        case (state_nxt)
          W_PWR: PWR_GATE <= PWR_GATE & ~sel_mask;
          W_CLK: CLK_HOLD <= CLK_HOLD & ~cur_mask;
          W_RST: RST_HOLD <= RST_HOLD & ~cur_mask;
          W_ISO: ISO      <= ISO & ~cur_mask;
          S_ISO: begin
            ISO       <= ISO | sel_mask;
            DOMAIN_ON <= DOMAIN_ON & ~sel_mask;
          end
          S_RST: RST_HOLD <= RST_HOLD | cur_mask;
          S_CLK: CLK_HOLD <= CLK_HOLD | cur_mask;
          S_PWR: PWR_GATE <= PWR_GATE | cur_mask;
          default: if (state == W_ISO) DOMAIN_ON <= DOMAIN_ON | cur_mask;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_pwr_seq.sv
// Bench for layer_pwr_seq: schedule-based reference model checked every cycle plus literal timing pins.
module tb_layer_pwr_seq;
  localparam int N = 2;
  localparam int D = 3;
`ifdef PWR_SEQ_INT_WAKE_EN
  localparam int IDOM = 1;
`else
  localparam int IDOM = 0;
`endif

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] WAKE_REQ = '0;
  logic [N-1:0] SLEEP_REQ = '0;
  logic [12:0]  int_vec = '0;
  logic [N-1:0] PWR_GATE, CLK_HOLD, RST_HOLD, ISO, DOMAIN_ON;
  logic         BUSY, DONE;
  logic [2:0]   DONE_ID;

  always #5 CLK = ~CLK;

  layer_pwr_seq #(.NUM_DOMAINS(N), .SEQ_DELAY(D), .INT_DEPTH(13), .INT_DOMAIN(IDOM)) dut (
    .CLK(CLK), .RESET(RESET), .WAKE_REQ(WAKE_REQ), .SLEEP_REQ(SLEEP_REQ),
`ifdef PWR_SEQ_INT_WAKE_EN
    .INT_VECTOR(int_vec),
`endif
    .PWR_GATE(PWR_GATE), .CLK_HOLD(CLK_HOLD), .RST_HOLD(RST_HOLD), .ISO(ISO),
    .DOMAIN_ON(DOMAIN_ON), .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: controls indexed 0=PWR_GATE 1=CLK_HOLD 2=RST_HOLD 3=ISO; a sequence is a
  // schedule of four steps D cycles apart, measured from the first visible change.
  logic [N-1:0] m_ctl [4];
  logic [N-1:0] m_on;
  logic [N-1:0] m_we;
  logic [2:0]   m_id;
  bit           m_active, m_wake, m_done, m_valid, m_found;
  int           m_p, m_dom;

  task automatic apply_step(input int k);
    if (m_wake) m_ctl[k][m_dom] = 1'b0;
    else begin
      m_ctl[3-k][m_dom] = 1'b1;
      if (k == 0) m_on[m_dom] = 1'b0;
    end
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < 4; k++) m_ctl[k] = '1;
      m_on = '0; m_active = 0; m_done = 0; m_id = 3'd0; m_valid = 1;
    end else if (m_valid) begin
      if (m_active) begin
        m_p++;
        if (m_p == 4*D) begin
          m_active = 0;
          m_done   = 1;
          if (m_wake) m_on[m_dom] = 1'b1;
        end else if (m_p % D == 0) apply_step(m_p / D);
      end else if (m_done) begin
        m_done = 0;
      end else begin
        m_we = WAKE_REQ;
`ifdef PWR_SEQ_INT_WAKE_EN
        if (int_vec != 0) m_we[IDOM] = 1'b1;
`endif
        m_found = 0;
        for (int i = 0; i < N; i++) begin
          if (!m_found && ((m_we[i] && !m_on[i]) || (SLEEP_REQ[i] && !m_we[i] && m_on[i]))) begin
            m_found = 1; m_dom = i; m_wake = m_we[i];
          end
        end
        if (m_found) begin
          m_active = 1; m_p = 0; m_id = 3'(m_dom);
          apply_step(0);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_pwr_gate", 8'(PWR_GATE), 8'(m_ctl[0]));
      chk("model_clk_hold", 8'(CLK_HOLD), 8'(m_ctl[1]));
      chk("model_rst_hold", 8'(RST_HOLD), 8'(m_ctl[2]));
      chk("model_iso", 8'(ISO), 8'(m_ctl[3]));
      chk("model_domain_on", 8'(DOMAIN_ON), 8'(m_on));
      chk("model_busy", 8'(BUSY), 8'(m_active));
      chk("model_done", 8'(DONE), 8'(m_done));
      chk("model_done_id", 8'(DONE_ID), 8'(m_id));
    end
  end

  int cyc = 0;
  int t0 = 0;
  task automatic step();
    @(posedge CLK); #1; cyc++;
  endtask
  task automatic upto(input int c);
    while (cyc < t0 + c) step();
  endtask

  initial begin
    step(); step();
    chk("reset_pwr", 8'(PWR_GATE), 8'h03);
    chk("reset_iso", 8'(ISO), 8'h03);
    chk("reset_on", 8'(DOMAIN_ON), 8'h00);
    chk("reset_busy", 8'(BUSY), 8'h00);

    // Wake domain 0; request dropped mid-sequence.
    t0 = cyc; RESET = 1'b0; WAKE_REQ = 2'b01;
    upto(1);  chk("w0_pwr_c1", 8'(PWR_GATE), 8'h02); chk("w0_busy_c1", 8'(BUSY), 8'h01);
    upto(2);  WAKE_REQ = 2'b00;
    upto(3);  chk("w0_clk_c3", 8'(CLK_HOLD), 8'h03);
    upto(4);  chk("w0_clk_c4", 8'(CLK_HOLD), 8'h02);
    upto(7);  chk("w0_rst_c7", 8'(RST_HOLD), 8'h02);
    upto(10); chk("w0_iso_c10", 8'(ISO), 8'h02); chk("w0_on_c10", 8'(DOMAIN_ON), 8'h00);
    upto(13); chk("w0_done_c13", 8'(DONE), 8'h01); chk("w0_id_c13", 8'(DONE_ID), 8'h00);
              chk("w0_on_c13", 8'(DOMAIN_ON), 8'h01); chk("w0_busy_c13", 8'(BUSY), 8'h00);
    upto(14); chk("w0_idle_c14", 8'(BUSY), 8'h00);

    // Sleep domain 0.
    t0 = cyc; SLEEP_REQ = 2'b01;
    upto(1);  chk("s0_iso_c1", 8'(ISO), 8'h03); chk("s0_on_c1", 8'(DOMAIN_ON), 8'h00);
              SLEEP_REQ = 2'b00;
    upto(4);  chk("s0_rst_c4", 8'(RST_HOLD), 8'h03);
    upto(7);  chk("s0_clk_c7", 8'(CLK_HOLD), 8'h03);
    upto(10); chk("s0_pwr_c10", 8'(PWR_GATE), 8'h03);
    upto(13); chk("s0_done_c13", 8'(DONE), 8'h01);
    upto(14);

    // Wake both: lowest first, next selection one cycle after DONE.
    t0 = cyc; WAKE_REQ = 2'b11;
    upto(13); chk("w2_done0", 8'(DONE), 8'h01); chk("w2_id0", 8'(DONE_ID), 8'h00);
    upto(14); chk("w2_gap_busy", 8'(BUSY), 8'h00); chk("w2_gap_pwr", 8'(PWR_GATE), 8'h02);
    upto(15); chk("w2_pwr1_c15", 8'(PWR_GATE), 8'h00); chk("w2_id1_c15", 8'(DONE_ID), 8'h01);
              WAKE_REQ = 2'b00;
    upto(27); chk("w2_done1", 8'(DONE), 8'h01); chk("w2_id1", 8'(DONE_ID), 8'h01);
              chk("w2_on", 8'(DOMAIN_ON), 8'h03);
    upto(28);

    // Wake+sleep together on an on domain is a wake: nothing happens.
    t0 = cyc; WAKE_REQ = 2'b11; SLEEP_REQ = 2'b11;
    upto(5);  chk("both_busy", 8'(BUSY), 8'h00); chk("both_on", 8'(DOMAIN_ON), 8'h03);

    // Sleep domain 1 only; domain 0 controls must not move.
    t0 = cyc; WAKE_REQ = 2'b00; SLEEP_REQ = 2'b10;
    upto(1);  chk("s1_iso_c1", 8'(ISO), 8'h02); chk("s1_on_c1", 8'(DOMAIN_ON), 8'h01);
              SLEEP_REQ = 2'b00;
    upto(13); chk("s1_done", 8'(DONE), 8'h01); chk("s1_id", 8'(DONE_ID), 8'h01);
              chk("s1_pwr", 8'(PWR_GATE), 8'h02);
    upto(14);

    // Reset in the middle of a domain-1 wake.
    t0 = cyc; WAKE_REQ = 2'b10;
    upto(1);  chk("r_pwr_c1", 8'(PWR_GATE), 8'h00);
    upto(5);  RESET = 1'b1;
    upto(6);  chk("r_pwr_c6", 8'(PWR_GATE), 8'h03); chk("r_clk_c6", 8'(CLK_HOLD), 8'h03);
              chk("r_rst_c6", 8'(RST_HOLD), 8'h03); chk("r_iso_c6", 8'(ISO), 8'h03);
              chk("r_busy_c6", 8'(BUSY), 8'h00); chk("r_on_c6", 8'(DOMAIN_ON), 8'h00);
              chk("r_id_c6", 8'(DONE_ID), 8'h00);
              RESET = 1'b0; WAKE_REQ = 2'b00;
    upto(8);  chk("r_idle_c8", 8'(BUSY), 8'h00);

`ifdef PWR_SEQ_INT_WAKE_EN
    // Interrupt wakes domain 1 despite a sleep request on it.
    t0 = cyc; int_vec = 13'h0004; SLEEP_REQ = 2'b10;
    upto(1);  chk("int_pwr_c1", 8'(PWR_GATE), 8'h01); int_vec = '0; SLEEP_REQ = 2'b00;
    upto(13); chk("int_done", 8'(DONE), 8'h01); chk("int_id", 8'(DONE_ID), 8'h01);
    upto(14);
`endif

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
